// File: rtl/msx_trace_pkg.sv
// ---------------------------------------------------------------------------
// msx_trace_pkg
// Shared definitions for the MSX bus-cycle trace block: record layout,
// bus-cycle kind encodings, capture FSM states and the address-window helper.
// ---------------------------------------------------------------------------
package msx_trace_pkg;

  // Record layout: {kind[1:0], m1, addr[15:0], data[7:0]}
  localparam int REC_W        = 27;
  localparam int REC_DATA_LSB = 0;
  localparam int REC_ADDR_LSB = 8;
  localparam int REC_M1_BIT   = 24;
  localparam int REC_KIND_LSB = 25;

  // Bus-cycle kinds: bit 1 = I/O space, bit 0 = write
  localparam logic [1:0] KIND_MEM_RD = 2'b00;
  localparam logic [1:0] KIND_MEM_WR = 2'b01;
  localparam logic [1:0] KIND_IO_RD  = 2'b10;
  localparam logic [1:0] KIND_IO_WR  = 2'b11;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE,  // waiting out any bus cycle already in flight at reset
    ST_IDLE,       // between cycles, looking for the next active sample
    ST_ACTIVE      // inside a cycle, tracking the latest data
  } cap_state_e;

  // Inclusive window test; kept as a function so constant bounds such as
  // 16'h0000 do not turn into always-true comparisons at the call site.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Synchronous first-word-fall-through FIFO. rdata shows the head entry while
// the FIFO is not empty and reads as zero when empty. A push into a full FIFO
// is accepted only when a pop happens in the same clock.
//   clk, reset   : clock, synchronous active-high reset
//   push, wdata  : write request and record
//   pop          : remove head entry (ignored while empty)
//   rdata        : head entry
//   empty, full  : occupancy flags
//   level        : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 27
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_FULL);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this clock, so a push into a full FIFO still fits.
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop)      level_d = level_q + LVL_ONE;
    else if (!do_push && do_pop) level_d = level_q - LVL_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; the cleared level and pointers
  // already make stale contents invisible, and unreset RAM maps to memory.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/msx_bus_trace.sv
// ---------------------------------------------------------------------------
// msx_bus_trace
// Samples the MSX Z80 bus on clk_enable, detects completed memory and I/O
// read/write cycles, filters them through the arm gate and address window,
// and buffers packed records in a FWFT FIFO drained by valid/ready.
//   clk, reset         : clock, synchronous active-high reset
//   clk_enable         : bus sample strobe; the capture FSM advances only here
//   bus_*              : Z80 address, data and active-low strobes
//   arm                : capture enable, evaluated at the start of each cycle
//   rec_valid/ready    : record handshake (pops ignore clk_enable)
//   rec_data           : head record {kind, m1, addr, data}
//   level              : FIFO occupancy
//   overflow           : dropped-record count, saturating at 255
// ---------------------------------------------------------------------------
module msx_bus_trace
  import msx_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter logic [15:0] ADDR_LO = 16'h0000,
  parameter logic [15:0] ADDR_HI = 16'hFFFF,
  parameter bit          IO_EN   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_enable,
  input  logic [15:0]            bus_addr,
  input  logic [7:0]             bus_data,
  input  logic                   bus_mreq_n,
  input  logic                   bus_iorq_n,
  input  logic                   bus_rd_n,
  input  logic                   bus_wr_n,
  input  logic                   bus_m1_n,
  input  logic                   arm,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [REC_W-1:0]       rec_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             overflow
);

  cap_state_e  state_q;
  logic [1:0]  kind_q;
  logic        m1_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        keep_q;
  logic [7:0]  overflow_q, overflow_d;

  logic             bus_active, is_io, is_wr, keep_now;
  logic [1:0]       kind_now;
  logic             push, pop, fifo_empty, fifo_full;
  logic [REC_W-1:0] rec_in;

  // Refresh and interrupt-acknowledge never assert rd/wr, so they never qualify.
  assign bus_active = (!bus_mreq_n || !bus_iorq_n) && (!bus_rd_n || !bus_wr_n);
  assign is_io      = !bus_iorq_n;
  assign is_wr      = !bus_wr_n;
  assign kind_now   = is_io ? (is_wr ? KIND_IO_WR  : KIND_IO_RD)
                            : (is_wr ? KIND_MEM_WR : KIND_MEM_RD);
  assign keep_now   = arm && (is_io ? IO_EN : in_window(bus_addr, ADDR_LO, ADDR_HI));

  // Push on the first enabled sample that sees the tracked cycle finished.
  assign push = clk_enable && (state_q == ST_ACTIVE) && !bus_active && keep_q;
  assign pop  = rec_valid && rec_ready;

  always_comb begin
    rec_in = '0;
    rec_in[REC_DATA_LSB +: 8]  = data_q;
    rec_in[REC_ADDR_LSB +: 16] = addr_q;
    rec_in[REC_M1_BIT]         = m1_q;
    rec_in[REC_KIND_LSB +: 2]  = kind_q;
  end

  // Capture FSM; kind, m1, addr and keep are frozen at the first sample,
  // data follows every active sample so late read data is what gets recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT_IDLE;
      kind_q  <= '0;
      m1_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      keep_q  <= 1'b0;
    end else if (clk_enable) begin
      unique case (state_q)
        ST_WAIT_IDLE: begin
          if (!bus_active) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus_active) begin
            kind_q  <= kind_now;
            m1_q    <= !bus_m1_n;
            addr_q  <= bus_addr;
            data_q  <= bus_data;
            keep_q  <= keep_now;
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (bus_active) data_q  <= bus_data;
          else            state_q <= ST_IDLE;
        end
        default: state_q <= ST_WAIT_IDLE;
      endcase
    end
  end

  // A push only drops when the FIFO is full and no pop frees a slot this clock.
  always_comb begin
    overflow_d = overflow_q;
    if (push && fifo_full && !pop && (overflow_q != 8'hFF))
      overflow_d = overflow_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) overflow_q <= '0;
    else       overflow_q <= overflow_d;
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (rec_in),
    .pop   (pop),
    .rdata (rec_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign rec_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule
